// File: rtl/rv_idx_pipe_pkg.sv
// Shared configuration for the ID/EX elastic register: datapath defaults,
// decoded-control field layout and the pipe state encoding.
package rv_configs;

   localparam int unsigned XLEN_DEF = 32;

   // Decoded-control bundle as produced by the decoder; the pipe carries it opaquely.
   typedef struct packed {
      logic [4:0] alu_op;
      logic [2:0] br_op;
      logic [2:0] mem_op;
      logic       mem_we;
      logic       reg_we;
      logic [1:0] wb_sel;
      logic       a_sel;
      logic       b_sel;
      logic [2:0] imm_type;
      logic       csr_en;
      logic [2:0] csr_op;
   } ctrl_t;

   localparam int unsigned CTRL_W_DEF = $bits(ctrl_t);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } idx_state_t;

endpackage

// File: rtl/rv_idx_pipe_if.sv
// ID/EX handshake and payload bundle. master = the pipe register itself,
// slave = the surrounding decode/execute logic.
interface rv_idx_pipe_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned CTRL_W = 24
);
   logic              i_idx_flush;
   logic              i_idx_valid;
   logic              o_idx_ready;
   logic [XLEN-1:0]   i_idx_pc;
   logic [XLEN-1:0]   i_idx_imm;
   logic [XLEN-1:0]   i_idx_rd1;
   logic [XLEN-1:0]   i_idx_rd2;
   logic [CTRL_W-1:0] i_idx_ctrl;
   logic [4:0]        i_idx_ra1;
   logic [4:0]        i_idx_ra2;
   logic [4:0]        i_idx_wa;
   logic              i_idx_fwd_we;
   logic [4:0]        i_idx_fwd_wa;
   logic [XLEN-1:0]   i_idx_fwd_wd;
   logic              o_idx_valid;
   logic              i_idx_ready;
   logic [XLEN-1:0]   o_idx_pc;
   logic [XLEN-1:0]   o_idx_imm;
   logic [XLEN-1:0]   o_idx_rd1;
   logic [XLEN-1:0]   o_idx_rd2;
   logic [CTRL_W-1:0] o_idx_ctrl;
   logic [4:0]        o_idx_ra1;
   logic [4:0]        o_idx_ra2;
   logic [4:0]        o_idx_wa;

   modport master (
      input  i_idx_flush, i_idx_valid, i_idx_pc, i_idx_imm, i_idx_rd1, i_idx_rd2,
             i_idx_ctrl, i_idx_ra1, i_idx_ra2, i_idx_wa,
             i_idx_fwd_we, i_idx_fwd_wa, i_idx_fwd_wd, i_idx_ready,
      output o_idx_ready, o_idx_valid, o_idx_pc, o_idx_imm, o_idx_rd1, o_idx_rd2,
             o_idx_ctrl, o_idx_ra1, o_idx_ra2, o_idx_wa
   );

   modport slave (
      output i_idx_flush, i_idx_valid, i_idx_pc, i_idx_imm, i_idx_rd1, i_idx_rd2,
             i_idx_ctrl, i_idx_ra1, i_idx_ra2, i_idx_wa,
             i_idx_fwd_we, i_idx_fwd_wa, i_idx_fwd_wd, i_idx_ready,
      input  o_idx_ready, o_idx_valid, o_idx_pc, o_idx_imm, o_idx_rd1, o_idx_rd2,
             o_idx_ctrl, o_idx_ra1, o_idx_ra2, o_idx_wa
   );
endinterface

// File: rtl/rv_idx_pipe_opnd_fwd.sv
// Single-operand writeback bypass: replaces the operand when WB writes the
// same nonzero register this cycle.
module rv_idx_opnd_fwd #(
   parameter int unsigned XLEN = 32
) (
   input  logic [4:0]      i_ra,
   input  logic [XLEN-1:0] i_val,
   input  logic            i_fwd_we,
   input  logic [4:0]      i_fwd_wa,
   input  logic [XLEN-1:0] i_fwd_wd,
   output logic [XLEN-1:0] o_val
);
   logic w_hit;

   // x0 is hardwired zero, so a write to it must never be forwarded.
   assign w_hit = i_fwd_we && (i_fwd_wa != 5'd0) && (i_fwd_wa == i_ra);
   assign o_val = w_hit ? i_fwd_wd : i_val;
endmodule

// File: rtl/rv_idx_pipe.sv
// Two-entry elastic ID/EX register (head + skid) with capture-time WB bypass.
// Define RV_IDX_HOLD_FWD_EN to also refresh operands of held entries from WB.
module rv_idx_pipe
   import rv_configs::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned CTRL_W = CTRL_W_DEF
) (
   input logic            i_idx_clk,
   input logic            i_idx_rst,
   rv_idx_pipe_if.master  bus
);
   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [CTRL_W-1:0] ctrl;
      logic [4:0]        ra1;
      logic [4:0]        ra2;
      logic [4:0]        wa;
   } ent_t;

   idx_state_t      r_state;
   logic            r_ready;
   ent_t            r_head;
   ent_t            r_skid;
   ent_t            w_cap;
   ent_t            w_head_hold;
   ent_t            w_skid_hold;
   logic [XLEN-1:0] w_cap_rd1;
   logic [XLEN-1:0] w_cap_rd2;
   logic            w_accept;
   logic            w_issue;

   assign w_accept = bus.i_idx_valid && r_ready;
   assign w_issue  = (r_state != EMPTY) && bus.i_idx_ready;

   rv_idx_opnd_fwd #(.XLEN(XLEN)) u_cap_rd1 (
      .i_ra(bus.i_idx_ra1), .i_val(bus.i_idx_rd1), .i_fwd_we(bus.i_idx_fwd_we),
      .i_fwd_wa(bus.i_idx_fwd_wa), .i_fwd_wd(bus.i_idx_fwd_wd), .o_val(w_cap_rd1));
   rv_idx_opnd_fwd #(.XLEN(XLEN)) u_cap_rd2 (
      .i_ra(bus.i_idx_ra2), .i_val(bus.i_idx_rd2), .i_fwd_we(bus.i_idx_fwd_we),
      .i_fwd_wa(bus.i_idx_fwd_wa), .i_fwd_wd(bus.i_idx_fwd_wd), .o_val(w_cap_rd2));

   always_comb begin
      w_cap      = '0;
      w_cap.pc   = bus.i_idx_pc;
      w_cap.imm  = bus.i_idx_imm;
      w_cap.rd1  = w_cap_rd1;
      w_cap.rd2  = w_cap_rd2;
      w_cap.ctrl = bus.i_idx_ctrl;
      w_cap.ra1  = bus.i_idx_ra1;
      w_cap.ra2  = bus.i_idx_ra2;
      w_cap.wa   = bus.i_idx_wa;
   end

`ifdef RV_IDX_HOLD_FWD_EN
   logic [XLEN-1:0] w_hd_rd1, w_hd_rd2, w_sk_rd1, w_sk_rd2;

   rv_idx_opnd_fwd #(.XLEN(XLEN)) u_hd_rd1 (
      .i_ra(r_head.ra1), .i_val(r_head.rd1), .i_fwd_we(bus.i_idx_fwd_we),
      .i_fwd_wa(bus.i_idx_fwd_wa), .i_fwd_wd(bus.i_idx_fwd_wd), .o_val(w_hd_rd1));
   rv_idx_opnd_fwd #(.XLEN(XLEN)) u_hd_rd2 (
      .i_ra(r_head.ra2), .i_val(r_head.rd2), .i_fwd_we(bus.i_idx_fwd_we),
      .i_fwd_wa(bus.i_idx_fwd_wa), .i_fwd_wd(bus.i_idx_fwd_wd), .o_val(w_hd_rd2));
   rv_idx_opnd_fwd #(.XLEN(XLEN)) u_sk_rd1 (
      .i_ra(r_skid.ra1), .i_val(r_skid.rd1), .i_fwd_we(bus.i_idx_fwd_we),
      .i_fwd_wa(bus.i_idx_fwd_wa), .i_fwd_wd(bus.i_idx_fwd_wd), .o_val(w_sk_rd1));
   rv_idx_opnd_fwd #(.XLEN(XLEN)) u_sk_rd2 (
      .i_ra(r_skid.ra2), .i_val(r_skid.rd2), .i_fwd_we(bus.i_idx_fwd_we),
      .i_fwd_wa(bus.i_idx_fwd_wa), .i_fwd_wd(bus.i_idx_fwd_wd), .o_val(w_sk_rd2));

   always_comb begin
      w_head_hold     = r_head;
      w_head_hold.rd1 = w_hd_rd1;
      w_head_hold.rd2 = w_hd_rd2;
      w_skid_hold     = r_skid;
      w_skid_hold.rd1 = w_sk_rd1;
      w_skid_hold.rd2 = w_sk_rd2;
   end
`else
   assign w_head_hold = r_head;
   assign w_skid_hold = r_skid;
`endif

   // Held entries are rewritten through the *_hold paths so the optional
   // refresh applies uniformly whether an entry stays put or moves to head.
   always_ff @(posedge i_idx_clk) begin
      if (i_idx_rst || bus.i_idx_flush) begin
         r_state <= EMPTY;
         r_ready <= 1'b1;
         r_head  <= '0;
         r_skid  <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_head  <= w_cap;
                  r_state <= ONE;
               end
            end
            ONE: begin
               if (w_accept && w_issue) begin
                  r_head <= w_cap;
               end else if (w_accept) begin
                  r_head  <= w_head_hold;
                  r_skid  <= w_cap;
                  r_state <= FULL;
                  r_ready <= 1'b0;
               end else if (w_issue) begin
                  r_state <= EMPTY;
               end else begin
                  r_head <= w_head_hold;
               end
            end
            FULL: begin
               if (w_issue) begin
                  r_head  <= w_skid_hold;
                  r_skid  <= '0;
                  r_state <= ONE;
                  r_ready <= 1'b1;
               end else begin
                  r_head <= w_head_hold;
                  r_skid <= w_skid_hold;
               end
            end
            default: begin
               r_state <= EMPTY;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.o_idx_ready = r_ready;
   assign bus.o_idx_valid = (r_state != EMPTY);
   assign bus.o_idx_pc    = r_head.pc;
   assign bus.o_idx_imm   = r_head.imm;
   assign bus.o_idx_rd1   = r_head.rd1;
   assign bus.o_idx_rd2   = r_head.rd2;
   assign bus.o_idx_ctrl  = r_head.ctrl;
   assign bus.o_idx_ra1   = r_head.ra1;
   assign bus.o_idx_ra2   = r_head.ra2;
   assign bus.o_idx_wa    = r_head.wa;
endmodule

// File: tb/tb_rv_idx_pipe.sv
// Directed bench for rv_idx_pipe: vector table plus reset and held-forward sequences.
// Expectations for held-operand refresh follow RV_IDX_HOLD_FWD_EN.
module tb_rv_idx_pipe;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   rv_idx_pipe_if #(.XLEN(32), .CTRL_W(24)) bus ();

   rv_idx_pipe #(.XLEN(32), .CTRL_W(24)) dut (
      .i_idx_clk(clk),
      .i_idx_rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        fwe;
      logic [4:0]  fwa;
      logic [31:0] fwd;
      logic        rdy;
      logic        fl;
      logic        e_v;
      logic        e_r;
      logic [31:0] e_pc;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic        e_z;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [4:0] ra1,
                               input logic [4:0] ra2, input logic fwe, input logic [4:0] fwa,
                               input logic [31:0] fwd, input logic rdy, input logic fl,
                               input logic e_v, input logic e_r, input logic [31:0] e_pc,
                               input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                               input logic e_z);
      vec_t t;
      t.v = v; t.pc = pc; t.ra1 = ra1; t.ra2 = ra2; t.fwe = fwe; t.fwa = fwa; t.fwd = fwd;
      t.rdy = rdy; t.fl = fl; t.e_v = e_v; t.e_r = e_r; t.e_pc = e_pc;
      t.e_rd1 = e_rd1; t.e_rd2 = e_rd2; t.e_z = e_z;
      return t;
   endfunction

   // Payload fields other than rd1/rd2 are derived from pc so they can be checked too.
   task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] ra1,
                        input logic [4:0] ra2, input logic fwe, input logic [4:0] fwa,
                        input logic [31:0] fwd, input logic rdy, input logic fl);
      bus.i_idx_valid  = v;
      bus.i_idx_pc     = pc;
      bus.i_idx_imm    = pc + 32'h100;
      bus.i_idx_rd1    = pc + 32'h1000;
      bus.i_idx_rd2    = pc + 32'h2000;
      bus.i_idx_ctrl   = pc[23:0] ^ 24'hA5A5A5;
      bus.i_idx_ra1    = ra1;
      bus.i_idx_ra2    = ra2;
      bus.i_idx_wa     = pc[6:2];
      bus.i_idx_fwd_we = fwe;
      bus.i_idx_fwd_wa = fwa;
      bus.i_idx_fwd_wd = fwd;
      bus.i_idx_ready  = rdy;
      bus.i_idx_flush  = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic e_v, input logic e_r,
                          input logic [31:0] e_pc, input logic [31:0] e_rd1,
                          input logic [31:0] e_rd2, input logic e_z);
      chk({nm, ".valid"}, 32'(bus.o_idx_valid), 32'(e_v));
      chk({nm, ".ready"}, 32'(bus.o_idx_ready), 32'(e_r));
      if (e_v || e_z) begin
         chk({nm, ".pc"},   bus.o_idx_pc,  e_z ? 32'h0 : e_pc);
         chk({nm, ".rd1"},  bus.o_idx_rd1, e_z ? 32'h0 : e_rd1);
         chk({nm, ".rd2"},  bus.o_idx_rd2, e_z ? 32'h0 : e_rd2);
         chk({nm, ".imm"},  bus.o_idx_imm, e_z ? 32'h0 : e_pc + 32'h100);
         chk({nm, ".ctrl"}, 32'(bus.o_idx_ctrl), e_z ? 32'h0 : 32'(e_pc[23:0] ^ 24'hA5A5A5));
         chk({nm, ".wa"},   32'(bus.o_idx_wa),   e_z ? 32'h0 : 32'(e_pc[6:2]));
      end
   endtask

   initial begin
      logic [31:0] e_hold;
      n_chk  = 0;
      n_fail = 0;

      // Streaming: one entry per cycle, latency 1, ready stays high.
      for (int k = 0; k < 8; k++)
         tv.push_back(mk(1'b1, 32'(k * 4), 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                         1'b1, 1'b1, 32'(k * 4), 32'(k * 4 + 32'h1000), 32'(k * 4 + 32'h2000), 1'b0));
      tv.push_back(mk(1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                      1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0));
      // Backpressure: 0x10 held, 0x14 to skid, 0x18 refused while full.
      tv.push_back(mk(1'b1, 32'h10, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                      1'b1, 1'b1, 32'h10, 32'h1010, 32'h2010, 1'b0));
      tv.push_back(mk(1'b1, 32'h14, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                      1'b1, 1'b0, 32'h10, 32'h1010, 32'h2010, 1'b0));
      tv.push_back(mk(1'b1, 32'h18, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                      1'b1, 1'b0, 32'h10, 32'h1010, 32'h2010, 1'b0));
      tv.push_back(mk(1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                      1'b1, 1'b1, 32'h14, 32'h1014, 32'h2014, 1'b0));
      tv.push_back(mk(1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                      1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0));
      // Capture bypass: rd1 hit, x0 never forwarded, rd2 hit, address mismatch.
      tv.push_back(mk(1'b1, 32'h20, 5'd5, 5'd2, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0,
                      1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 32'h2020, 1'b0));
      tv.push_back(mk(1'b1, 32'h24, 5'd0, 5'd2, 1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 1'b0,
                      1'b1, 1'b1, 32'h24, 32'h1024, 32'h2024, 1'b0));
      tv.push_back(mk(1'b1, 32'h28, 5'd3, 5'd9, 1'b1, 5'd9, 32'hCAFEF00D, 1'b1, 1'b0,
                      1'b1, 1'b1, 32'h28, 32'h1028, 32'hCAFEF00D, 1'b0));
      tv.push_back(mk(1'b1, 32'h2C, 5'd4, 5'd6, 1'b1, 5'd5, 32'h11111111, 1'b0, 1'b0,
                      1'b1, 1'b0, 32'h28, 32'h1028, 32'hCAFEF00D, 1'b0));
      // Flush while full with a valid input: everything dropped.
      tv.push_back(mk(1'b1, 32'h30, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
                      1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1));
      tv.push_back(mk(1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                      1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1));
      tv.push_back(mk(1'b1, 32'h34, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                      1'b1, 1'b1, 32'h34, 32'h1034, 32'h2034, 1'b0));
      tv.push_back(mk(1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                      1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0));

      rst = 1'b1;
      drive(1'b1, 32'h44, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      chk_out("reset", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
      rst = 1'b0;

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].v, tv[i].pc, tv[i].ra1, tv[i].ra2, tv[i].fwe, tv[i].fwa, tv[i].fwd,
               tv[i].rdy, tv[i].fl);
         tick();
         chk_out($sformatf("vec%0d", i), tv[i].e_v, tv[i].e_r, tv[i].e_pc, tv[i].e_rd1,
                 tv[i].e_rd2, tv[i].e_z);
      end

      // Reset while full discards both entries.
      drive(1'b1, 32'h40, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h44, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
      chk_out("rst_fill", 1'b1, 1'b0, 32'h40, 32'h1040, 32'h2040, 1'b0);
      rst = 1'b1;
      drive(1'b1, 32'h48, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      tick();
      chk_out("rst_full", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
      rst = 1'b0;
      drive(1'b0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      tick();
      chk_out("rst_after", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);

      // Held operands and WB writes: head rd2 via x7, skid rd1 via x8.
      drive(1'b1, 32'h50, 5'd1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
      chk_out("hold_load", 1'b1, 1'b1, 32'h50, 32'h1050, 32'h2050, 1'b0);
      drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 1'b0);
      tick();
`ifdef RV_IDX_HOLD_FWD_EN
      e_hold = 32'h1234;
`else
      e_hold = 32'h2050;
`endif
      chk_out("hold_head", 1'b1, 1'b1, 32'h50, 32'h1050, e_hold, 1'b0);
      drive(1'b1, 32'h54, 5'd8, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      tick();
      chk_out("hold_fill", 1'b1, 1'b0, 32'h50, 32'h1050, e_hold, 1'b0);
      drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd8, 32'h5678, 1'b0, 1'b0);
      tick();
      chk_out("hold_full", 1'b1, 1'b0, 32'h50, 32'h1050, e_hold, 1'b0);
      drive(1'b0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      tick();
`ifdef RV_IDX_HOLD_FWD_EN
      e_hold = 32'h5678;
`else
      e_hold = 32'h1054;
`endif
      chk_out("hold_skid", 1'b1, 1'b1, 32'h54, e_hold, 32'h2054, 1'b0);
      tick();
      chk_out("hold_drain", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rv_idx_pipe.md
RV_IDX_PIPE -- requirements
Module: rv_idx_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width of PC, immediate and operands.
REQ-002 Parameter CTRL_W, default 24: width of packed decoded-control bundle.
REQ-003 Clock and reset: one clock, i_idx_clk; reset i_idx_rst is synchronous and active-high.
REQ-004 Port list; width W is XLEN unless stated:
- i_idx_clk  in  1  clock
- i_idx_rst  in  1  synchronous active-high reset
- i_idx_flush  in  1  drop all held entries
- i_idx_valid  in  1  upstream entry valid
- o_idx_ready  out  1  block can accept
- i_idx_pc, i_idx_imm, i_idx_rd1, i_idx_rd2  in  W  upstream payload
- i_idx_ctrl  in  CTRL_W  decoded control
- i_idx_ra1, i_idx_ra2, i_idx_wa  in  5  source and dest register addresses
- i_idx_fwd_we  in  1  WB write strobe
- i_idx_fwd_wa  in  5  WB write address
- i_idx_fwd_wd  in  W  WB write data
- o_idx_valid  out  1  head entry valid
- i_idx_ready  in  1  downstream accepts
- o_idx_pc, o_idx_imm, o_idx_rd1, o_idx_rd2, o_idx_ctrl, o_idx_ra1, o_idx_ra2, o_idx_wa  out  as input  head payload

Function
REQ-005 Two-entry elastic ID/EX register: head register drives outputs; skid register holds one overflow entry.
REQ-006 States EMPTY (no entries), ONE (head only), FULL (head + skid); no other encodings reachable.
REQ-007 Accept = i_idx_valid && o_idx_ready; issue = o_idx_valid && i_idx_ready.
REQ-008 o_idx_ready SHALL be registered and equal 1 iff skid empty; o_idx_valid equals 1 iff head occupied.
REQ-009 EMPTY + accept -> ONE; payload visible on outputs the next cycle (latency 1).
REQ-010 ONE + accept + issue -> ONE with new head; ONE + accept, no issue -> FULL, input to skid; ONE + issue, no accept -> EMPTY.
REQ-011 FULL + issue -> ONE, skid moves to head; no accept is possible in FULL.
REQ-012 Order strictly FIFO; sustained throughput one entry per cycle while i_idx_ready=1.
REQ-013 Capture bypass: when capturing, if i_idx_fwd_we && i_idx_fwd_wa!=0 && i_idx_fwd_wa==ra1 (ra2), store i_idx_fwd_wd as rd1 (rd2) instead of i_idx_rd1 (rd2).
REQ-014 Flush: next cycle -> EMPTY, all payload fields zero, o_idx_ready=1; flush wins over simultaneous accept or issue, and the input is dropped.
REQ-015 Register x0 never matches a forward.

Reset
REQ-016 On i_idx_rst: state EMPTY, o_idx_valid=0, o_idx_ready=1, all payload outputs 0, skid contents 0.
REQ-017 Reset mid-operation discards both entries within one cycle; reset has priority over flush.

Configuration
REQ-018 Macro RV_IDX_HOLD_FWD_EN defined: every cycle, each occupied entry whose ra1/ra2 matches a valid nonzero WB write replaces that operand with i_idx_fwd_wd (head and skid independently).
REQ-019 Macro absent: held operands are never modified after capture; only REQ-013 applies.

Structure
REQ-020 Shared package (rv_configs): XLEN default, the CTRL_W field layout, and the 2-bit state encodings EMPTY=0, ONE=1, FULL=2.
REQ-021 One sub-module, rv_idx_opnd_fwd: compare plus mux for a single operand, instantiated at capture and, under the macro, per held entry.

Verification
REQ-022 Stream 8 entries, pc=0x00..0x1C, i_idx_ready=1 -> outputs in order, one per cycle, 1-cycle latency, o_idx_ready=1 throughout.
REQ-023 i_idx_ready=0 after entry pc=0x10 is accepted, then send pc=0x14 -> FULL and o_idx_ready=0; release ready -> 0x10 then 0x14 issued, nothing lost or duplicated.
REQ-024 Capture with ra1=5, fwd_we=1, fwd_wa=5, fwd_wd=0xDEADBEEF -> o_idx_rd1=0xDEADBEEF; same with wa=0 -> i_idx_rd1 kept.
REQ-025 In FULL, pulse flush together with i_idx_valid=1 -> next cycle o_idx_valid=0, payload outputs 0, o_idx_ready=1, input not stored.
REQ-026 Macro on: head held with ra2=7, WB writes x7=0x1234 -> o_idx_rd2=0x1234 next cycle; macro off -> unchanged.
REQ-027 Assert i_idx_rst while FULL -> EMPTY next cycle with all outputs per REQ-016.
